muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 op  input  3  operation: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
REQ-006 a  input  32  rs operand, the same value the EX-stage ALU receives as a.
REQ-007 b  input  32  rt operand, the same value the EX-stage ALU receives as b.
REQ-008 flush  input  1  pipeline flush; aborts the in-flight operation.
REQ-009 busy  output  1  operation in progress; the hazard unit stalls MFHI/MFLO and new mult/div on it.
REQ-010 done  output  1  one-cycle pulse when hi/lo take a mult/div result.
REQ-011 hi  output  32  HI register.
REQ-012 lo  output  32  LO register.

Function
REQ-013 FSM states SHALL be IDLE, MUL, DIV, FIX.
- IDLE + start + MULT/MULTU -> MUL.
- IDLE + start + DIV/DIVU -> DIV.
- MUL or DIV, after 32 iterations -> FIX.
- FIX -> IDLE.
REQ-014 On the capture edge, operands SHALL be latched; a and b MAY change afterwards.
REQ-015 Signed ops SHALL latch operand magnitudes and a sign flag; unsigned ops latch operands as-is.
REQ-016 busy SHALL be high in MUL, DIV and FIX, and low in IDLE.
REQ-017 MUL SHALL perform a radix-2 shift-add, one bit per cycle, with a 64-bit accumulator.
REQ-018 DIV SHALL perform restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
REQ-019 A 6-bit iteration counter SHALL run 0..31; the transition to FIX occurs on count 31.
REQ-020 FIX SHALL apply sign correction, write hi/lo, and assert done in that same cycle.
REQ-021 Latency SHALL be 34 cycles from the start edge to done (1 capture + 32 iterations + 1 FIX).
REQ-022 Multiply results SHALL be hi = product[63:32], lo = product[31:0].
REQ-023 Divide results SHALL be lo = quotient, hi = remainder.
REQ-024 Signed divide: quotient negative iff operand signs differ; remainder takes the dividend's sign.
REQ-025 Divide by zero SHALL give lo = 32'hFFFF_FFFF, hi = a, with full 34-cycle latency.
REQ-026 Signed 0x8000_0000 / -1 SHALL give lo = 32'h8000_0000, hi = 0.
REQ-027 MTHI/MTLO in IDLE with start SHALL write a into hi/lo at that edge, with no busy and no done.
REQ-028 start while busy SHALL be ignored; no queueing.
REQ-029 start with an undefined op SHALL be ignored.
REQ-030 flush SHALL return the FSM to IDLE next edge, leave hi/lo unchanged and suppress done.
REQ-031 flush has priority over start in the same cycle.
REQ-032 flush in FIX SHALL suppress both the write and done.
REQ-033 hi/lo SHALL change only in FIX or on MTHI/MTLO.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, busy = 0, done = 0, hi = 0, lo = 0 and counter = 0, including mid-operation.
REQ-035 No result SHALL be produced for an operation interrupted by reset.

Configuration
REQ-036 Macro MULDIV_DIV_EN defined: divide hardware present, behaviour as above.
REQ-037 MULDIV_DIV_EN undefined: divide datapath absent.
- DIV/DIVU SHALL complete in 2 cycles (IDLE->FIX) with hi = 0, lo = 0 and done asserted.
- Multiply is unaffected.

Structure
REQ-038 The MD_* op encodings SHALL live in the shared parameters.v include, alongside the ALU_* codes.
REQ-039 Divider iteration SHALL be a sub-module muldiv_div_step (one restoring step, combinational).
REQ-040 Counter, FSM and sign fix-up stay in muldiv_unit.

Verification
REQ-041 MULTU a = 32'hFFFF_FFFF, b = 32'hFFFF_FFFF -> after 34 cycles done = 1, hi = 32'hFFFF_FFFE, lo = 32'h0000_0001.
REQ-042 MULT a = -7, b = 6 -> hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFD6 (-42).
REQ-043 DIV a = -7, b = 2 -> lo = -3, hi = -1; DIVU a = 100, b = 7 -> lo = 14, hi = 2.
REQ-044 DIV a = 5, b = 0 -> lo = 32'hFFFF_FFFF, hi = 5; DIV a = 32'h8000_0000, b = -1 -> lo = 32'h8000_0000, hi = 0.
REQ-045 MULT started, flush at cycle 10 -> busy low next cycle, no done, hi/lo retain prior values; a second start at cycle 5 is ignored.
REQ-046 rst_n asserted at cycle 20 of a DIV -> busy = 0, hi = lo = 0 immediately; MTHI a = 3 afterwards -> hi = 3 next edge, done stays 0.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared operation encodings and operand helpers for the multiply/divide unit.
// Codes 6 and 7 are undefined and a start carrying them is ignored.
package muldiv_unit_pkg;

    localparam int MD_XLEN = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // A negative two's-complement operand is replaced by its magnitude.
    // Its sign is kept in a separate flag.
    function automatic logic [MD_XLEN-1:0] md_mag(input logic [MD_XLEN-1:0] v,
                                                  input logic                is_signed);
        return (is_signed && v[MD_XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One combinational restoring-division step: it shifts in one dividend bit and
// produces one quotient bit.
module muldiv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic            quo_bit
);

    logic [XLEN+1:0] shifted;

    always_comb begin
        shifted = {rem_in, dividend_bit};
        quo_bit = (shifted >= {2'b00, divisor});
        rem_out = quo_bit ? (shifted[XLEN:0] - {1'b0, divisor}) : shifted[XLEN:0];
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that holds the HI/LO registers.
// Define MULDIV_DIV_EN to build in the restoring divider. When it is not defined, DIV/DIVU return zero in two cycles.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write hi/lo here
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// FIX   | sign correction, hi/lo write, done
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;
    localparam logic [5:0] LAST_ITER = 6'(XLEN - 1);

    logic [1:0]        state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              is_div_q, is_div_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              sgn_op;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] prod_fix;

`ifdef MULDIV_DIV_EN
    logic [XLEN:0] rem_q, rem_d;
    logic [XLEN:0] step_rem;
    logic          step_bit;

    muldiv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_in       (rem_q),
        .dividend_bit (acc_q[XLEN-1]),
        .divisor      (opb_q),
        .rem_out      (step_rem),
        .quo_bit      (step_bit)
    );
`endif

    assign sgn_op   = (op == MD_MULT) || (op == MD_DIV);
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULDIV_DIV_EN
        rem_d    = rem_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                case (op)
                    MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                        acc_d    = {{XLEN{1'b0}}, md_mag(a, sgn_op)};
                        opb_d    = md_mag(b, sgn_op);
                        neg_a_d  = sgn_op & a[XLEN-1];
                        neg_b_d  = sgn_op & b[XLEN-1];
                        is_div_d = (op == MD_DIV) || (op == MD_DIVU);
                        cnt_d    = '0;
                        if (is_div_d) begin
`ifdef MULDIV_DIV_EN
                            state_d = DIV;
                            rem_d   = '0;
`else
                            state_d = FIX;
`endif
                        end else begin
                            state_d = MUL;
                        end
                    end
                    MD_MTHI: hi_d = a;
                    MD_MTLO: lo_d = a;
                    default: ;
                endcase
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            DIV: begin
`ifdef MULDIV_DIV_EN
                rem_d             = step_rem;
                acc_d[XLEN-1:0]   = {acc_q[XLEN-2:0], step_bit};
                cnt_d             = cnt_q + 6'd1;
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (is_div_q) begin
`ifdef MULDIV_DIV_EN
                    // The raw divide-by-zero result already leaves the dividend in the remainder.
                    // Only the quotient has to be forced to all ones.
                    lo_d = (opb_q == '0) ? '1 :
                           ((neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
                    hi_d = neg_a_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
`else
                    lo_d = '0;
                    hi_d = '0;
`endif
                end else begin
                    hi_d = prod_fix[2*XLEN-1:XLEN];
                    lo_d = prod_fix[XLEN-1:0];
                end
            end
        endcase
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
`ifdef MULDIV_DIV_EN
            rem_q    <= rem_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
